muldiv_iter: RTL and testbench
==============================

Name: muldiv_iter

Overview:
- Parametrised iterative multiply/divide unit implementing the RV64M operation set for the multicycle core, with RV32M as a subset.
- Sits beside the main ALU. The control unit issues a start pulse with operands taken from the A/B registers and stalls on busy. The result is written back through the MemToReg mux when done pulses.
- Computes one result bit per cycle, with a fast path for divide-by-zero and signed overflow.

Parameters:
- XLEN, 64, operand/result width; 32 or 64 only.
- HAS_W, 1, enables word-mode (*W) ops; must be 0 when XLEN=32.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  issue request; sampled only in IDLE.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- word  in  1  *W variant; ignored when HAS_W=0.
- opa  in  XLEN  rs1 operand.
- opb  in  XLEN  rs2 operand.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  registered result; held until the next accepted start.

Behaviour:
- Reset: state=IDLE; busy=0; done=0; result=0; all internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- States:
  - IDLE: accepts a start.
  - CALC: iterative bit loop.
  - FIX: sign correction.
  - DONE: result output.
- IDLE → CALC on start=1:
  - Latch op and word.
  - Latch operands, taking magnitudes for signed operand cases.
  - Latch negate flags for result sign.
  - Load iteration counter N, where N=32 if word else XLEN.
  - Word mode uses opa[31:0] and opb[31:0] only. Operand signedness is taken from bit 31.
- CALC:
  - Multiply: shift-add on a 2N-bit product, one multiplier bit per cycle.
  - Divide: restoring, one quotient bit per cycle.
  - Counter decrements each cycle; exits to FIX after N cycles.
- FIX (1 cycle): conditional two's-complement negation of the result, then output selection:
  - MUL: low N bits.
  - MULH/MULHSU/MULHU: high N bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Word mode: the 32-bit result is sign-extended to XLEN (all *W ops, including DIVUW/REMUW).
  - result is registered here.
- DONE (1 cycle): done=1, busy=0; next state IDLE.
- Latency: done is high exactly N+2 cycles after the accepting edge, i.e. 66 cycles for XLEN ops and 34 for word ops.
- Fast path, decided in IDLE at the accepting edge; CALC is skipped (IDLE → FIX → DONE), giving done 2 cycles after acceptance:
  - Divisor zero (low 32 bits in word mode): DIV/DIVU quotient = all ones; REM/REMU = dividend (word mode: sign-extended low 32 bits).
  - Signed overflow (DIV/REM with dividend = most-negative N-bit value and divisor = −1): quotient = dividend; remainder = 0.
- Signedness per op:
  - MULH: both operands signed.
  - MULHSU: opa signed, opb unsigned.
  - MULHU, DIVU, REMU: both unsigned.
  - Remainder sign follows the dividend; quotient sign is the XOR of the operand signs.
- start while busy=1 or done=1 is ignored; no queuing.
- start in the same cycle as done=1 is also ignored; the earliest accepted restart is the cycle after done.
- opa/opb/op/word may change freely after the accepting edge.
- busy and done are never high together.

Test Plan:
- XLEN=64, MUL, opa=7, opb=0xFFFFFFFFFFFFFFFD (−3) → result=0xFFFFFFFFFFFFFFEB; done exactly 66 cycles after start; busy high for cycles 1..65.
- MULHU, opa=opb=0xFFFFFFFFFFFFFFFF → result=0xFFFFFFFFFFFFFFFE. MULH with the same operands → 0. MULHSU with opa=−1, opb=2 → 0xFFFFFFFFFFFFFFFF.
- DIVU, opa=100, opb=0 → result=0xFFFFFFFFFFFFFFFF with done at cycle 2. REM, opa=100, opb=0 → 100 with done at cycle 2.
- DIV, opa=0x8000000000000000, opb=−1 → 0x8000000000000000. REM with the same operands → 0. Both take the 2-cycle fast path.
- Word ops:
  - DIVW, opa=0x12345678FFFFFFF9 (low word −7), opb=2 → 0xFFFFFFFFFFFFFFFD with done at cycle 34.
  - REMW with the same operands → 0xFFFFFFFFFFFFFFFF.
  - MULW, opa=0x10000, opb=0x10000 → 0.
- Control:
  - A second start during busy is ignored, and the first result (DIV 20/−6 = −3) is unaffected.
  - rst asserted at cycle 30 of a MUL → busy=0, result=0 next cycle, no done pulse.
  - A following start behaves normally.

Source files
------------

// File: rtl/muldiv_iter.sv
// Iterative RV64M/RV32M multiply/divide unit: one result bit per cycle,
// with a two-cycle fast path for divide-by-zero and signed overflow.
module muldiv_iter #(
    parameter int XLEN  = 64,
    parameter bit HAS_W = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic            word,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int SH = XLEN - 32;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    // Place a 32-bit value in XLEN bits, sign-extending when s is set.
    function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic s);
        logic [XLEN-1:0] r;
        r       = {XLEN{s & v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic            r_word;
    logic [2:0]      r_op;
    logic            r_neg_a;
    logic            r_neg_b;
    logic            r_dz;
    logic            r_ov;
    logic [XLEN-1:0] r_m;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_lo;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_result;

    logic            w_word;
    logic            w_sgn_a;
    logic            w_sgn_b;
    logic            w_neg_a;
    logic            w_neg_b;
    logic            w_b_zero;
    logic            w_ovf;
    logic            w_fast;
    logic [XLEN-1:0] w_a_val;
    logic [XLEN-1:0] w_b_val;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;

    // Issue-time decode: operand extension, magnitudes and fast-path detection.
    always_comb begin
        w_word   = word & HAS_W;
        w_sgn_a  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        w_sgn_b  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        w_a_val  = w_word ? ext32(opa[31:0], w_sgn_a) : opa;
        w_b_val  = w_word ? ext32(opb[31:0], w_sgn_b) : opb;
        w_neg_a  = w_sgn_a & w_a_val[XLEN-1];
        w_neg_b  = w_sgn_b & w_b_val[XLEN-1];
        w_a_mag  = w_neg_a ? -w_a_val : w_a_val;
        w_b_mag  = w_neg_b ? -w_b_val : w_b_val;
        w_b_zero = w_word ? (opb[31:0] == 32'd0) : (opb == '0);
        w_ovf    = ((op == OP_DIV) || (op == OP_REM)) &&
                   (w_word ? ((opa[31:0] == 32'h8000_0000) && (opb[31:0] == 32'hFFFF_FFFF))
                           : ((opa == {1'b1, {(XLEN-1){1'b0}}}) && (opb == '1)));
        w_fast   = op[2] & (w_b_zero | w_ovf);
    end

    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_sh;
    logic            w_div_ge;
    logic [XLEN-1:0] w_div_sub;

    assign w_mul_sum = {1'b0, r_acc} + {1'b0, (r_lo[0] ? r_m : '0)};
    assign w_div_sh  = {r_acc, r_lo[XLEN-1]};
    assign w_div_ge  = w_div_sh >= {1'b0, r_m};
    // The difference is below the divisor whenever it is used, so XLEN bits suffice.
    assign w_div_sub = w_div_sh[XLEN-1:0] - r_m;

    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_mul_hi;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_res_x;
    logic [XLEN-1:0]   w_res;

    // NOTE: every signal driven here gets a value on every path, so no latch is inferred.
    always_comb begin
        w_prod = {r_acc, r_lo};
        // A 32-iteration product is left-aligned by XLEN-32 in the shift pair.
        if (r_word) begin
            w_prod = w_prod >> SH;
        end
        w_prod_s = (r_neg_a ^ r_neg_b) ? -w_prod : w_prod;
        w_mul_hi = r_word ? ext32(w_prod_s[63:32], 1'b0) : w_prod_s[2*XLEN-1:XLEN];

        if (r_dz) begin
            w_quo = '1;
        end else if (r_ov) begin
            w_quo = r_lo;
        end else begin
            w_quo = (r_neg_a ^ r_neg_b) ? -r_lo : r_lo;
        end

        if (r_dz) begin
            w_rem = r_lo;
        end else if (r_ov) begin
            w_rem = '0;
        end else begin
            w_rem = r_neg_a ? -r_acc : r_acc;
        end

        case (r_op)
            OP_MUL:                 w_res_x = w_prod_s[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_res_x = w_mul_hi;
            3'b100, 3'b101:         w_res_x = w_quo;
            default:                w_res_x = w_rem;
        endcase

        w_res = r_word ? ext32(w_res_x[31:0], 1'b1) : w_res_x;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = w_fast ? S_FIX : S_CALC;
            S_CALC:  if (r_cnt == CW'(1)) w_next = S_FIX;
            S_FIX:   w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == S_CALC) || (r_state == S_FIX);
        done = (r_state == S_DONE);
    end

    assign result = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_word   <= 1'b0;
            r_op     <= '0;
            r_neg_a  <= 1'b0;
            r_neg_b  <= 1'b0;
            r_dz     <= 1'b0;
            r_ov     <= 1'b0;
            r_m      <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_op    <= op;
                        r_word  <= w_word;
                        r_neg_a <= w_neg_a;
                        r_neg_b <= w_neg_b;
                        r_dz    <= op[2] & w_b_zero;
                        r_ov    <= w_ovf;
                        r_acc   <= '0;
                        r_cnt   <= w_word ? CW'(32) : CW'(XLEN);
                        if (w_fast) begin
                            r_m  <= w_b_val;
                            r_lo <= w_a_val;
                        end else if (op[2]) begin
                            r_m  <= w_b_mag;
                            r_lo <= w_word ? (w_a_mag << SH) : w_a_mag;
                        end else begin
                            r_m  <= w_a_mag;
                            r_lo <= w_b_mag;
                        end
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt - CW'(1);
                    if (r_op[2]) begin
                        r_acc <= w_div_ge ? w_div_sub : w_div_sh[XLEN-1:0];
                        r_lo  <= {r_lo[XLEN-2:0], w_div_ge};
                    end else begin
                        r_acc <= w_mul_sum[XLEN:1];
                        r_lo  <= {w_mul_sum[0], r_lo[XLEN-1:1]};
                    end
                end
                S_FIX: begin
                    r_result <= w_res;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Self-checking bench for muldiv_iter (XLEN=64): directed corner cases plus
// randomized operations against an arithmetic reference model.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic        word;
    logic [63:0] opa;
    logic [63:0] opb;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_iter #(.XLEN(64), .HAS_W(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .word   (word),
        .opa    (opa),
        .opb    (opb),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] sx32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Reference result straight from the RV64M definitions.
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic w,
                                               input logic [63:0] a, input logic [63:0] b);
        logic [127:0] pa, pb, pp;
        logic         sa, sb, sgn;
        logic [31:0]  x, y, q32, r32;
        logic [63:0]  q64, r64;
        int           xi, yi;
        longint       xl, yl;
        if (!o[2]) begin
            sa = (o == 3'b001) || (o == 3'b010);
            sb = (o == 3'b001);
            if (w) begin
                pa = {{96{sa & a[31]}}, a[31:0]};
                pb = {{96{sb & b[31]}}, b[31:0]};
                pp = pa * pb;
                return (o == 3'b000) ? sx32(pp[31:0]) : sx32(pp[63:32]);
            end
            pa = {{64{sa & a[63]}}, a};
            pb = {{64{sb & b[63]}}, b};
            pp = pa * pb;
            return (o == 3'b000) ? pp[63:0] : pp[127:64];
        end
        sgn = !o[0];
        if (w) begin
            x = a[31:0];
            y = b[31:0];
            if (y == 0) begin
                q32 = '1; r32 = x;
            end else if (sgn && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                q32 = x; r32 = 0;
            end else if (sgn) begin
                xi = x; yi = y;
                q32 = xi / yi; r32 = xi % yi;
            end else begin
                q32 = x / y; r32 = x % y;
            end
            return sx32(o[1] ? r32 : q32);
        end
        if (b == 0) begin
            q64 = '1; r64 = a;
        end else if (sgn && a == 64'h8000_0000_0000_0000 && b == '1) begin
            q64 = a; r64 = 0;
        end else if (sgn) begin
            xl = a; yl = b;
            q64 = xl / yl; r64 = xl % yl;
        end else begin
            q64 = a / b; r64 = a % b;
        end
        return o[1] ? r64 : q64;
    endfunction

    function automatic int ref_latency(input logic [2:0] o, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
        logic bz, ov;
        bz = w ? (b[31:0] == 0) : (b == 0);
        ov = !o[0] && (w ? (a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF)
                         : (a == 64'h8000_0000_0000_0000 && b == '1));
        if (o[2] && (bz || ov)) return 2;
        return w ? 34 : 66;
    endfunction

    function automatic logic [63:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 64'd0;
            1:       return '1;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'($urandom_range(0, 20));
            4:       return {32'($urandom), 32'h8000_0000};
            5:       return {32'($urandom), 32'h0};
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    // Issue one op, follow it to done, and check latency, busy, result and
    // that a start presented alongside done is ignored.
    task automatic run_op(input string tag, input logic [2:0] o, input logic w,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_r, input int exp_lat, input int inj);
        int cyc;
        int busy_bad;
        @(negedge clk);
        start = 1'b1; op = o; word = w; opa = a; opb = b;
        @(negedge clk);
        start = 1'b0;
        op = 3'($urandom); word = 1'($urandom);
        opa = {32'($urandom), 32'($urandom)}; opb = {32'($urandom), 32'($urandom)};
        cyc = 1;
        busy_bad = 0;
        while (cyc < 200) begin
            if (done) break;
            if (!busy) busy_bad++;
            start = (cyc == inj);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check({tag, "/latency"}, 64'(cyc), 64'(exp_lat));
        check({tag, "/busy_low_before_done"}, 64'(busy_bad), 64'd0);
        check({tag, "/result"}, result, exp_r);
        check({tag, "/busy_with_done"}, 64'(busy), 64'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "/start_on_done_ignored"}, 64'({busy, done}), 64'd0);
    endtask

    task automatic reset_mid_op();
        int cyc;
        int n_act;
        @(negedge clk);
        start = 1'b1; op = 3'b000; word = 1'b0;
        opa = 64'h0123_4567_89AB_CDEF; opb = 64'h0000_0000_0000_1234;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid/busy", 64'(busy), 64'd0);
        check("rst_mid/done", 64'(done), 64'd0);
        check("rst_mid/result", result, 64'd0);
        n_act = 0;
        repeat (80) begin
            @(negedge clk);
            if (done || busy) n_act++;
        end
        check("rst_mid/no_done", 64'(n_act), 64'd0);
    endtask

    initial begin
        logic [2:0]  o;
        logic        w;
        logic [63:0] a, b;

        rst = 1'b1; start = 1'b0; op = '0; word = 1'b0; opa = '0; opb = '0;
        repeat (3) @(negedge clk);
        check("reset/busy", 64'(busy), 64'd0);
        check("reset/done", 64'(done), 64'd0);
        check("reset/result", result, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("mul", 3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD,
               64'hFFFF_FFFF_FFFF_FFEB, 66, 0);
        run_op("mulhu", 3'b011, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0);
        run_op("mulh", 3'b001, 1'b0, '1, '1, 64'd0, 66, 0);
        run_op("mulhsu", 3'b010, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 66, 0);
        run_op("divu_by0", 3'b101, 1'b0, 64'd100, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2, 0);
        run_op("rem_by0", 3'b110, 1'b0, 64'd100, 64'd0, 64'd100, 2, 0);
        run_op("div_ovf", 3'b100, 1'b0, 64'h8000_0000_0000_0000, '1,
               64'h8000_0000_0000_0000, 2, 0);
        run_op("rem_ovf", 3'b110, 1'b0, 64'h8000_0000_0000_0000, '1, 64'd0, 2, 0);
        run_op("divw", 3'b100, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 34, 0);
        run_op("remw", 3'b110, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFF, 34, 0);
        run_op("mulw", 3'b000, 1'b1, 64'h1_0000, 64'h1_0000, 64'd0, 34, 0);
        run_op("div_busy_start", 3'b100, 1'b0, 64'd20, 64'hFFFF_FFFF_FFFF_FFFA,
               64'hFFFF_FFFF_FFFF_FFFD, 66, 10);

        reset_mid_op();
        run_op("after_rst", 3'b101, 1'b0, 64'd1000, 64'd7, 64'd142, 66, 0);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom);
            w = 1'($urandom);
            if (o == 3'b001 || o == 3'b010 || o == 3'b011) w = 1'b0;
            a = rnd_operand();
            b = rnd_operand();
            run_op($sformatf("rnd%0d_op%0d_w%0d", i, o, w), o, w, a, b,
                   ref_result(o, w, a, b), ref_latency(o, w, a, b), 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
